// File: rtl/score_checker.sv
// -----------------------------------------------------------------------------
// score_checker
//
// End-of-game score bookkeeping. A one-cycle checkscore pulse captures the
// final score and player ID. The score is compared against that player's best
// and the global high score, then converted to three BCD digits by a
// serial double-dabble (one shift per clock, 7 shifts).
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   checkscore    one-cycle capture request (ignored while busy)
//   PlayerScore   7-bit final score, valid with checkscore
//   playerid      player ID, valid with checkscore
//   busy          high from the capture edge until done
//   done          one-cycle pulse when the digit outputs update
//   newhigh       one-cycle pulse when a new global high score is recorded
//   HighScore     global high score
//   HighPlayer    ID of the high-score holder
//   PlayerBest    best score of the live playerid (combinational read)
//   ScoreHundreds/ScoreTens/ScoreOnes  BCD digits of the last captured score
// -----------------------------------------------------------------------------
module score_checker #(
    parameter int PLAYER_ID_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   checkscore,
    input  logic [6:0]             PlayerScore,
    input  logic [PLAYER_ID_W-1:0] playerid,
    output logic                   busy,
    output logic                   done,
    output logic                   newhigh,
    output logic [6:0]             HighScore,
    output logic [PLAYER_ID_W-1:0] HighPlayer,
    output logic [6:0]             PlayerBest,
    output logic [3:0]             ScoreHundreds,
    output logic [3:0]             ScoreTens,
    output logic [3:0]             ScoreOnes
);

    localparam int NUM_PLAYERS = 1 << PLAYER_ID_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPARE = 2'b01,
        ST_CONVERT = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_capture;
    logic                   w_compare;
    logic                   w_shift;
    logic                   w_last_shift;

    logic [6:0]             r_score;
    logic [PLAYER_ID_W-1:0] r_id;
    logic [6:0]             r_best [NUM_PLAYERS];
    logic [6:0]             r_high;
    logic [PLAYER_ID_W-1:0] r_high_player;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_newhigh;

    // Double-dabble working registers: BCD accumulator above the binary value.
    logic [6:0]             r_bin;
    logic [11:0]            r_bcd;
    logic [2:0]             r_cnt;
    logic [3:0]             r_hundreds;
    logic [3:0]             r_tens;
    logic [3:0]             r_ones;

    logic [3:0]             w_adj [3];
    logic [11:0]            w_bcd_adj;
    logic [18:0]            w_shifted;

    // ------------------------------------------------------------------
    // Double-dabble step: add 3 to every nibble >= 5, then shift the whole
    // {bcd, bin} pair left by one. A 7-bit value fits in 12 BCD bits, so
    // dropping the MSB of the adjusted BCD can never lose information.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign w_adj[gi] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                           : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_bcd_adj = {w_adj[2], w_adj[1], w_adj[0]};
    assign w_shifted = {w_bcd_adj[10:0], r_bin, 1'b0};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-state control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_compare    = 1'b0;
        w_shift      = 1'b0;
        w_last_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (checkscore) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_compare    = 1'b1;
                w_state_next = ST_CONVERT;
            end
            ST_CONVERT: begin
                w_shift = 1'b1;
                // r_cnt counts completed shifts; 6 means this edge is the 7th.
                if (r_cnt == 3'd6) begin
                    w_last_shift = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score       <= '0;
            r_id          <= '0;
            r_high        <= '0;
            r_high_player <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_newhigh     <= 1'b0;
            r_bin         <= '0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            r_hundreds    <= '0;
            r_tens        <= '0;
            r_ones        <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_best[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_newhigh <= 1'b0;

            if (w_capture) begin
                r_score <= PlayerScore;
                r_id    <= playerid;
                r_busy  <= 1'b1;
            end

            if (w_compare) begin
                if (r_score > r_best[r_id]) begin
                    r_best[r_id] <= r_score;
                end
                // Strict compare: a tie leaves the existing holder in place.
                if (r_score > r_high) begin
                    r_high        <= r_score;
                    r_high_player <= r_id;
                    r_newhigh     <= 1'b1;
                end
                r_bin <= r_score;
                r_bcd <= '0;
                r_cnt <= '0;
            end

            if (w_shift) begin
                r_bcd <= w_shifted[18:7];
                r_bin <= w_shifted[6:0];
                r_cnt <= r_cnt + 3'd1;
                if (w_last_shift) begin
                    r_hundreds <= w_shifted[18:15];
                    r_tens     <= w_shifted[14:11];
                    r_ones     <= w_shifted[10:7];
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign newhigh       = r_newhigh;
    assign HighScore     = r_high;
    assign HighPlayer    = r_high_player;
    assign PlayerBest    = r_best[playerid];
    assign ScoreHundreds = r_hundreds;
    assign ScoreTens     = r_tens;
    assign ScoreOnes     = r_ones;

endmodule

// File: tb/tb_score_checker.sv
// -----------------------------------------------------------------------------
// tb_score_checker
//
// Scoreboard bench for score_checker. Each capture pushes its hand-computed
// expectation (digits, high score, holder, done edge, newhigh edge) into a
// queue; a monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_score_checker;

    logic       clk;
    logic       rst;
    logic       checkscore;
    logic [6:0] PlayerScore;
    logic [1:0] playerid;
    logic       busy;
    logic       done;
    logic       newhigh;
    logic [6:0] HighScore;
    logic [1:0] HighPlayer;
    logic [6:0] PlayerBest;
    logic [3:0] ScoreHundreds;
    logic [3:0] ScoreTens;
    logic [3:0] ScoreOnes;

    score_checker #(.PLAYER_ID_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .checkscore    (checkscore),
        .PlayerScore   (PlayerScore),
        .playerid      (playerid),
        .busy          (busy),
        .done          (done),
        .newhigh       (newhigh),
        .HighScore     (HighScore),
        .HighPlayer    (HighPlayer),
        .PlayerBest    (PlayerBest),
        .ScoreHundreds (ScoreHundreds),
        .ScoreTens     (ScoreTens),
        .ScoreOnes     (ScoreOnes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dig;       // {hundreds, tens, ones} as 3 hex nibbles
        int hs;
        int hp;
        int done_cyc;
        int nh_cyc;    // -1 when no newhigh pulse is expected
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nh_seen = -1;
    int   done_count = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: track newhigh pulses, check every done against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            nh_seen = -1;
        end else begin
            if (newhigh) begin
                if (nh_seen != -1) chk("newhigh_double", cyc, nh_seen);
                nh_seen = cyc;
            end
            if (done) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("txn: digits %0d%0d%0d high=%0d holder=%0d done@%0d newhigh@%0d",
                             ScoreHundreds, ScoreTens, ScoreOnes, HighScore, HighPlayer,
                             cyc, nh_seen);
                    chk("digits", int'({ScoreHundreds, ScoreTens, ScoreOnes}), e.dig);
                    chk("high_score", int'(HighScore), e.hs);
                    chk("high_player", int'(HighPlayer), e.hp);
                    chk("done_latency", cyc, e.done_cyc);
                    chk("newhigh_edge", nh_seen, e.nh_cyc);
                    chk("busy_at_done", int'(busy), 0);
                end
                nh_seen = -1;
            end
        end
    end

    // Issue one capture and wait for the block to go idle again.
    task automatic do_op(input int id, input int sc, input int eh, input int et,
                         input int eo, input int ehs, input int ehp, input bit enh);
        exp_t e;
        int   n;
        @(negedge clk);
        checkscore  = 1'b1;
        playerid    = 2'(id);
        PlayerScore = 7'(sc);
        n           = cyc + 1;              // capture edge number
        e.dig       = (eh << 8) | (et << 4) | eo;
        e.hs        = ehs;
        e.hp        = ehp;
        e.done_cyc  = n + 8;
        e.nh_cyc    = enh ? n + 1 : -1;
        sb_q.push_back(e);
        @(negedge clk);
        checkscore = 1'b0;
        chk("busy_after_capture", int'(busy), 1);
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    task automatic chk_best(input int id, input int exp);
        playerid = 2'(id);
        #1;
        chk($sformatf("player_best%0d", id), int'(PlayerBest), exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_newhigh"}, int'(newhigh), 0);
        chk({tag, "_high"}, int'(HighScore), 0);
        chk({tag, "_holder"}, int'(HighPlayer), 0);
        chk({tag, "_digits"}, int'({ScoreHundreds, ScoreTens, ScoreOnes}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int dc;
        rst         = 1'b0;
        checkscore  = 1'b0;
        PlayerScore = '0;
        playerid    = '0;
        #2;
        chk_all_zero("por");
        for (int i = 0; i < 4; i++) chk_best(i, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic capture, tie, maximum, lower score by the same player.
        do_op(1, 42, 0, 4, 2, 42, 1, 1'b1);
        do_op(2, 42, 0, 4, 2, 42, 1, 1'b0);
        @(negedge clk);
        chk_best(2, 42);
        chk_best(1, 42);
        do_op(3, 127, 1, 2, 7, 127, 3, 1'b1);
        do_op(3, 5, 0, 0, 5, 127, 3, 1'b0);
        @(negedge clk);
        chk_best(3, 127);

        // Second checkscore at N+3 must be ignored.
        dc = done_count;
        @(negedge clk);
        checkscore  = 1'b1;
        playerid    = 2'd0;
        PlayerScore = 7'd99;
        begin
            exp_t e;
            e.dig = 12'h099; e.hs = 127; e.hp = 3;
            e.done_cyc = cyc + 9; e.nh_cyc = -1;
            sb_q.push_back(e);
        end
        @(negedge clk);                      // after edge N
        checkscore = 1'b0;
        @(negedge clk);                      // after edge N+1
        @(negedge clk);                      // after edge N+2
        checkscore  = 1'b1;                  // sampled at edge N+3
        playerid    = 2'd1;
        PlayerScore = 7'd120;
        @(negedge clk);
        checkscore = 1'b0;
        repeat (10) @(negedge clk);
        chk("single_done", done_count - dc, 1);
        chk_best(1, 42);
        chk_best(0, 99);

        // Asynchronous reset in the middle of CONVERT.
        dc = done_count;
        @(negedge clk);
        checkscore  = 1'b1;
        playerid    = 2'd1;
        PlayerScore = 7'd126;
        @(negedge clk);                      // after edge N
        checkscore = 1'b0;
        repeat (3) @(posedge clk);           // edge N+3
        @(posedge clk);                      // edge N+4
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        chk_best(1, 0);
        chk_best(3, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_count - dc, 0);
        do_op(2, 7, 0, 0, 7, 7, 2, 1'b1);

        // Full sweep from a clean state.
        do_reset();
        for (int s = 0; s < 128; s++) begin
            do_op(s % 4, s, s / 100, (s / 10) % 10, s % 10, s, (s == 0) ? 0 : s % 4, s != 0);
        end

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        chk("queue_drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
